singleport_ram_master: RTL

//  Initiator for singleport_ram: turns a valid/ready command stream (read/write) into the RAM's
//  wr_en/rd_en/addr strobes. Owns the shared bidirectional data bus, including turnaround.

---
 rtl/singleport_ram_pkg.sv | 37 +++
 rtl/singleport_ram_master_if.sv | 34 +++
 rtl/singleport_ram_rsp_fifo.sv | 70 +++++++
 rtl/singleport_ram_master.sv | 105 ++++++++++
 4 files changed

// File: rtl/singleport_ram_pkg.sv
// ----------------------------------------------------------------------------
// singleport_ram_pkg
//   Shared definitions for the singleport_ram master slice.
//   - WIDTH_DEF / DEPTH_DEF : default data width and RAM depth
//   - addr_w()              : address width for a given depth (minimum 1 bit)
//   - cmd_t / rsp_t         : command / response records at the default sizes
//   - guard_state_t         : post-reset guard state of the master
// ----------------------------------------------------------------------------
package singleport_ram_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned DEPTH_DEF = 16;

    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned ADDR_W_DEF = addr_w(DEPTH_DEF);

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [WIDTH_DEF-1:0]  wdata;
    } cmd_t;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] rdata;
    } rsp_t;

    // ST_GUARD covers the first cycle after reset release, while the RAM's
    // un-reset output enable may still be draining.
    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_RUN   = 1'b1
    } guard_state_t;

endpackage

// File: rtl/singleport_ram_master_if.sv
// ----------------------------------------------------------------------------
// singleport_ram_master_if
//   Client-side command/response streams of singleport_ram_master.
//   cmd_valid/cmd_ready/cmd_we/cmd_addr/cmd_wdata : command stream
//   rsp_valid/rsp_ready/rsp_rdata                 : read response stream
//   modport master : the client (issues commands, consumes responses)
//   modport slave  : singleport_ram_master
// ----------------------------------------------------------------------------
interface singleport_ram_master_if #(
    parameter int unsigned WIDTH = singleport_ram_pkg::WIDTH_DEF,
    parameter int unsigned AW    = singleport_ram_pkg::ADDR_W_DEF
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [AW-1:0]    cmd_addr;
    logic [WIDTH-1:0] cmd_wdata;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/singleport_ram_rsp_fifo.sv
// ----------------------------------------------------------------------------
// singleport_ram_rsp_fifo
//   Synchronous FIFO holding read responses, DEPTH x WIDTH, show-ahead head.
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push        : write push_data (ignored when full unless popping)
//   push_data   : data to enqueue
//   pop         : remove head entry (ignored when empty)
//   pop_data    : current head entry
//   valid       : FIFO not empty
//   count       : number of stored entries
// ----------------------------------------------------------------------------
module singleport_ram_rsp_fifo #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned COUNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   pop_data,
    output logic               valid,
    output logic [COUNT_W-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop & (count != '0);
        do_push = push & ((count != COUNT_W'(DEPTH)) | do_pop);
    end

    assign valid    = (count != '0);
    assign pop_data = store[rd_ptr];

    // Storage needs no reset: count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/singleport_ram_master.sv
// ----------------------------------------------------------------------------
// singleport_ram_master
//   Initiator for one singleport_ram. Converts a valid/ready command stream
//   into single-cycle wr_en/rd_en/addr strobes, owns the shared data bus
//   (including read->write turnaround) and queues returned read data into a
//   valid/ready response stream, in command order.
//   clk, rst_n  : clock shared with the RAM, asynchronous active-low reset
//   cmd_if      : command / response streams (slave side)
//   mem_wr_en   : RAM write strobe (one cycle per accepted write)
//   mem_rd_en   : RAM read strobe (one cycle per accepted read)
//   mem_addr    : RAM word address, valid while a strobe is high
//   mem_dinout  : shared data bus; driven only while mem_wr_en=1, else 'z
//
//   Read timeline (accept at end of cycle k):
//     k+1 mem_rd_en, k+2 RAM drives bus and data is captured into the FIFO,
//     k+3 rsp_valid (with an empty FIFO).
// ----------------------------------------------------------------------------
module singleport_ram_master
    import singleport_ram_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    singleport_ram_master_if.slave    cmd_if,
    output logic                      mem_wr_en,
    output logic                      mem_rd_en,
    output logic [addr_w(DEPTH)-1:0]  mem_addr,
    inout  wire  [WIDTH-1:0]          mem_dinout
);

    localparam int unsigned AW = addr_w(DEPTH);
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

    guard_state_t     gstate;
    logic [WIDTH-1:0] wdata_q;
    logic             cap_q;       // read whose data is on the bus this cycle
    logic             credit_ok;
    logic             cmd_ready_c;
    logic             accept;
    logic [CW:0]      occupancy;

    logic [CW-1:0]    fifo_count;
    logic             fifo_valid;
    logic [WIDTH-1:0] fifo_head;

    // Credits: queued responses plus reads in the issue (mem_rd_en) and
    // capture (cap_q) stages must leave room for one more entry, so the FIFO
    // can never overflow even with rsp_ready held low.
    // Writes are refused while mem_rd_en=1 because the RAM drives the bus in
    // the next cycle, which is when the write would drive it too.
    always_comb begin
        occupancy   = (CW + 1)'(fifo_count) + (CW + 1)'(mem_rd_en) + (CW + 1)'(cap_q);
        credit_ok   = (occupancy < (CW + 1)'(RSP_DEPTH));
        cmd_ready_c = (gstate == ST_RUN) & (cmd_if.cmd_we ? ~mem_rd_en : credit_ok);
        accept      = cmd_if.cmd_valid & cmd_ready_c;
    end

    assign cmd_if.cmd_ready = cmd_ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gstate    <= ST_GUARD;
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            wdata_q   <= '0;
            cap_q     <= 1'b0;
        end else begin
            gstate    <= ST_RUN;
            mem_wr_en <= accept & cmd_if.cmd_we;
            mem_rd_en <= accept & ~cmd_if.cmd_we;
            if (accept) begin
                mem_addr <= AW'(cmd_if.cmd_addr);
                wdata_q  <= cmd_if.cmd_wdata;
            end
            cap_q     <= mem_rd_en;
        end
    end

    // Bus enable is the registered write strobe, so reset releases the bus
    // immediately and it is never enabled right after a read strobe.
    assign mem_dinout = mem_wr_en ? wdata_q : 'z;

    singleport_ram_rsp_fifo #(
        .WIDTH   (WIDTH),
        .DEPTH   (RSP_DEPTH),
        .COUNT_W (CW)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cap_q),
        .push_data (mem_dinout),
        .pop       (cmd_if.rsp_ready),
        .pop_data  (fifo_head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign cmd_if.rsp_valid = fifo_valid;
    assign cmd_if.rsp_rdata = fifo_head;

endmodule
